ahb_imem: RTL

- Clocked, parametrised AHB-Lite slave memory; next generation of the combinational boot ROM.
- Serves instruction fetch and data load/store on the core's 64-bit HADDR/HWDATA/HRDATA bus.
- Adds byte/half/word/dword sizes with lane strobes, configurable wait states, a read-only mode and AHB error responses.
- Sits behind the bus decoder at MEM_START.

---
 rtl/ahb_imem_if.sv | 24 ++
 rtl/ahb_imem.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_imem_if.sv
// AHB-Lite bus bundle between the core-side decoder and the instruction/data memory.
interface ahb_imem_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  HSEL;
  logic [1:0]            HTRANS;
  logic [63:0]           HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HSEL, HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_imem.sv
// Clocked AHB-Lite slave memory: byte/half/word/dword accesses with lane strobes,
// programmable wait states, optional read-only mode and two-cycle ERROR responses.
module ahb_imem #(
  parameter int          DATA_WIDTH  = 64,
  parameter int          MEM_BYTES   = 256,
  parameter logic [63:0] MEM_START   = 64'h0,
  parameter int          WAIT_STATES = 1,
  parameter bit          READ_ONLY   = 1'b0,
  parameter string       INIT_FILE   = ""
) (
  input  logic      HCLK,
  input  logic      HRESET,
  ahb_imem_if.slave bus
);

  localparam int L     = DATA_WIDTH / 8;
  localparam int LB    = $clog2(L);
  localparam int WORDS = MEM_BYTES / L;
  localparam int IW    = $clog2(WORDS);
  localparam int AW    = $clog2(MEM_BYTES);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] RESP = 3'd2;
  localparam logic [2:0] ERR1 = 3'd3;
  localparam logic [2:0] ERR2 = 3'd4;

  // Power-up image: byte i holds i[7:0].
  function automatic logic [WORDS-1:0][DATA_WIDTH-1:0] init_image();
    logic [DATA_WIDTH-1:0] img [WORDS];
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < L; b++) begin
        img[w][b*8 +: 8] = 8'(w * L + b);
      end
    end
    for (int w = 0; w < WORDS; w++) begin
      init_image[w] = img[w];
    end
  endfunction

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [63:0] size_mask(input logic [2:0] size);
    size_mask = (64'd1 << size) - 64'd1;
  endfunction

  // Byte lanes touched by an access of 2^size bytes starting at the given lane.
  function automatic logic [L-1:0] lane_be(input logic [LB-1:0] lane, input logic [2:0] size);
    int lo;
    int n;
    lane_be = '0;
    lo      = int'(lane);
    n       = 1 << size;
    for (int l = 0; l < L; l++) begin
      lane_be[l] = (l >= lo) && (l < lo + n);
    end
  endfunction

  logic [WORDS-1:0][DATA_WIDTH-1:0] mem = init_image();

  logic [2:0]            state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  ld_rd, ld_zero;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic [AW-1:0]         addr_p1;
  logic [2:0]            size_p1;
  logic                  write_p1;

  logic                  hready;
  logic                  accept;
  logic                  err;
  logic [63:0]           off;
  logic [IW-1:0]         bus_idx, wr_idx, rd_idx;
  logic [L-1:0]          be;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_ok;

  // HTRANS[0] only separates SEQ from NONSEQ (and BUSY from IDLE); both behave alike here.
  assign unused_ok = bus.HTRANS[0];

  assign hready  = (state == IDLE) || (state == RESP) || (state == ERR2);
  assign accept  = bus.HSEL && bus.HTRANS[1] && hready;
  assign off     = bus.HADDR - MEM_START;
  assign bus_idx = off[AW-1:LB];

  // Offset is checked rather than MEM_START+MEM_BYTES so a window near the top never wraps.
  assign err = (bus.HADDR < MEM_START)
            || (off >= 64'(MEM_BYTES))
            || ((bus.HADDR & size_mask(bus.HSIZE)) != 64'd0)
            || (bus.HSIZE > 3'(LB))
            || (bus.HWRITE && READ_ONLY);

  assign wr_idx = addr_p1[AW-1:LB];
  assign be     = lane_be(addr_p1[LB-1:0], size_p1);
  assign wr_en  = (state == RESP) && write_p1 && !HRESET;

  // Merge the write-data lanes into the current word; untouched lanes keep their bytes.
  always_comb begin
    merged = mem[wr_idx];
    for (int l = 0; l < L; l++) begin
      if (be[l]) merged[l*8 +: 8] = bus.HWDATA[l*8 +: 8];
    end
  end

  // A zero-wait read accepted on the commit edge of a write to the same word sees the new bytes.
  assign rd_idx  = (state == WAIT) ? wr_idx : bus_idx;
  assign rd_word = (wr_en && (rd_idx == wr_idx)) ? merged : mem[rd_idx];

  // Transfer sequencing: accept/pipeline from ready states, count waits, two-cycle error.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ld_rd   = 1'b0;
    ld_zero = 1'b0;
    case (state)
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
          ld_rd   = !write_p1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ERR1: begin
        state_n = ERR2;
        ld_zero = 1'b1;
      end
      default: begin
        if (accept) begin
          if (err) begin
            state_n = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_n = WAIT;
            cnt_n   = 4'(WAIT_STATES - 1);
          end else begin
            state_n = RESP;
            ld_rd   = !bus.HWRITE;
          end
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  // Control state and registered read data; reset aborts any transfer in flight.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      hrdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (ld_rd) begin
        hrdata_q <= rd_word;
      end else if (ld_zero) begin
        hrdata_q <= '0;
      end
    end
  end

  // Address-phase capture feeding the data phase.
  always_ff @(posedge HCLK) begin
    if (accept) begin
      addr_p1  <= off[AW-1:0];
      size_p1  <= bus.HSIZE;
      write_p1 <= bus.HWRITE;
    end
  end

  // Write commit at the end of the RESP cycle, when HWDATA is valid.
  always_ff @(posedge HCLK) begin
    if (wr_en) mem[wr_idx] <= merged;
  end

  assign bus.HRDATA = hrdata_q;
  assign bus.HREADY = hready;
  assign bus.HRESP  = (state == ERR1) || (state == ERR2);

endmodule
